// File: rtl/sensor_fval_lval_gen_pkg.sv
// -----------------------------------------------------------------------------
// sensor_fval_lval_gen_pkg
// Shared definitions for the sensor frame/line timing generator:
//   - 3-bit state encoding of the timing FSM
//   - CNT_W, width of the position counters and the duration down-counter
//   - param_range_ok(), elaboration-time check that every timing parameter
//     lies in 1..65535 (a zero duration would underflow the down-counter load)
// -----------------------------------------------------------------------------
package sensor_fval_lval_gen_pkg;

   localparam int CNT_W = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEAD   = 3'd1;
   localparam logic [2:0] ST_ACTIVE = 3'd2;
   localparam logic [2:0] ST_HBLANK = 3'd3;
   localparam logic [2:0] ST_TRAIL  = 3'd4;
   localparam logic [2:0] ST_VBLANK = 3'd5;

   // True when a single timing parameter fits the down-counter range.
   function automatic bit in_cnt_range(input int value);
      return (value >= 32'sd1) && (value <= 32'sd65535);
   endfunction

   // True when every timing parameter of the generator is legal.
   function automatic bit param_range_ok(input int h_active,
                                         input int h_blank,
                                         input int v_active,
                                         input int fval_lead,
                                         input int fval_trail,
                                         input int v_blank);
      return in_cnt_range(h_active)  && in_cnt_range(h_blank)    &&
             in_cnt_range(v_active)  && in_cnt_range(fval_lead)  &&
             in_cnt_range(fval_trail) && in_cnt_range(v_blank);
   endfunction

endpackage

// File: rtl/sensor_fval_lval_gen.sv
// -----------------------------------------------------------------------------
// sensor_fval_lval_gen
// Frame/line timing generator feeding the raw-file pixel reader. Produces
// frame-valid / line-valid strobes, pixel and line position counters and a
// one-cycle frame-done pulse. Frames run continuously or one per trigger; a
// started frame always runs to completion (only reset can cut it short).
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous, active-high reset
//   i_enable       in   run enable, only looked at when a frame could start
//   i_trigger_mode in   0 = continuous, 1 = one frame per trigger
//   i_trigger      in   single-cycle trigger pulse
//   o_fval         out  frame valid (LEAD, ACTIVE, HBLANK, TRAIL)
//   o_lval         out  line valid (ACTIVE only)
//   ov_pix_cnt     out  pixel index inside the active line, else 0
//   ov_line_cnt    out  line index inside the frame, else 0
//   o_frame_done   out  pulse in the first clock after o_fval falls
// -----------------------------------------------------------------------------
module sensor_fval_lval_gen
   import sensor_fval_lval_gen_pkg::*;
#(
   parameter int H_ACTIVE   = 160,
   parameter int H_BLANK    = 32,
   parameter int V_ACTIVE   = 480,
   parameter int FVAL_LEAD  = 8,
   parameter int FVAL_TRAIL = 8,
   parameter int V_BLANK    = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_enable,
   input  logic             i_trigger_mode,
   input  logic             i_trigger,
   output logic             o_fval,
   output logic             o_lval,
   output logic [CNT_W-1:0] ov_pix_cnt,
   output logic [CNT_W-1:0] ov_line_cnt,
   output logic             o_frame_done
);

   if (!param_range_ok(H_ACTIVE, H_BLANK, V_ACTIVE, FVAL_LEAD, FVAL_TRAIL, V_BLANK)) begin : g_param_check
      $error("sensor_fval_lval_gen: timing parameter outside 1..65535");
   end

   // Down-counter reload values: each state lasts (load + 1) clocks.
   localparam logic [CNT_W-1:0] LEAD_LOAD   = CNT_W'(FVAL_LEAD - 1);
   localparam logic [CNT_W-1:0] ACTIVE_LOAD = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HBLANK_LOAD = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] TRAIL_LOAD  = CNT_W'(FVAL_TRAIL - 1);
   localparam logic [CNT_W-1:0] VBLANK_LOAD = CNT_W'(V_BLANK - 1);
   localparam logic [CNT_W-1:0] LINE_LAST   = CNT_W'(V_ACTIVE - 1);

   logic [2:0]       state_r;
   logic [2:0]       state_nxt_s;
   logic [CNT_W-1:0] dcnt_r;
   logic [CNT_W-1:0] dcnt_nxt_s;
   logic [CNT_W-1:0] pix_nxt_s;
   logic [CNT_W-1:0] line_nxt_s;
   logic             fval_nxt_s;
   logic             lval_nxt_s;
   logic             done_nxt_s;
   logic             trig_pend_r;
   logic             start_ok_s;
   logic             expire_s;
   logic             consume_s;

   assign start_ok_s = i_enable && (!i_trigger_mode || trig_pend_r);
   assign expire_s   = (dcnt_r == {CNT_W{1'b0}});
   // A pending trigger is used up only by a frame start made in trigger mode.
   assign consume_s  = i_trigger_mode && (state_nxt_s == ST_LEAD) && (state_r != ST_LEAD);

   // Next-state and duration counter: reload on every state entry, else count down.
   always_comb begin
      state_nxt_s = state_r;
      dcnt_nxt_s  = dcnt_r;
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_nxt_s = ST_LEAD;
               dcnt_nxt_s  = LEAD_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
               dcnt_nxt_s  = {CNT_W{1'b0}};
            end
         end
         ST_LEAD: begin
            if (expire_s) begin
               state_nxt_s = ST_ACTIVE;
               dcnt_nxt_s  = ACTIVE_LOAD;
            end else begin
               dcnt_nxt_s  = dcnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_ACTIVE: begin
            if (expire_s && (ov_line_cnt == LINE_LAST)) begin
               state_nxt_s = ST_TRAIL;
               dcnt_nxt_s  = TRAIL_LOAD;
            end else if (expire_s) begin
               state_nxt_s = ST_HBLANK;
               dcnt_nxt_s  = HBLANK_LOAD;
            end else begin
               dcnt_nxt_s  = dcnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_HBLANK: begin
            if (expire_s) begin
               state_nxt_s = ST_ACTIVE;
               dcnt_nxt_s  = ACTIVE_LOAD;
            end else begin
               dcnt_nxt_s  = dcnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_TRAIL: begin
            if (expire_s) begin
               state_nxt_s = ST_VBLANK;
               dcnt_nxt_s  = VBLANK_LOAD;
            end else begin
               dcnt_nxt_s  = dcnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_VBLANK: begin
            // Back-to-back frames go straight to LEAD with no IDLE cycle.
            if (expire_s && start_ok_s) begin
               state_nxt_s = ST_LEAD;
               dcnt_nxt_s  = LEAD_LOAD;
            end else if (expire_s) begin
               state_nxt_s = ST_IDLE;
               dcnt_nxt_s  = {CNT_W{1'b0}};
            end else begin
               dcnt_nxt_s  = dcnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            dcnt_nxt_s  = {CNT_W{1'b0}};
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state so the
   // registered outputs switch on the same edge as the state register.
   always_comb begin
      fval_nxt_s = 1'b0;
      lval_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      pix_nxt_s  = {CNT_W{1'b0}};
      line_nxt_s = {CNT_W{1'b0}};
      case (state_nxt_s)
         ST_LEAD: begin
            fval_nxt_s = 1'b1;
         end
         ST_ACTIVE: begin
            fval_nxt_s = 1'b1;
            lval_nxt_s = 1'b1;
            if (state_r == ST_ACTIVE) begin
               pix_nxt_s = ov_pix_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               pix_nxt_s = {CNT_W{1'b0}};
            end
            if (state_r == ST_HBLANK) begin
               line_nxt_s = ov_line_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               line_nxt_s = ov_line_cnt;
            end
         end
         ST_HBLANK, ST_TRAIL: begin
            fval_nxt_s = 1'b1;
            line_nxt_s = ov_line_cnt;
         end
         ST_VBLANK: begin
            done_nxt_s = (state_r == ST_TRAIL);
         end
         default: begin
            fval_nxt_s = 1'b0;
         end
      endcase
   end

   // State, duration counter and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         dcnt_r       <= {CNT_W{1'b0}};
         o_fval       <= 1'b0;
         o_lval       <= 1'b0;
         o_frame_done <= 1'b0;
         ov_pix_cnt   <= {CNT_W{1'b0}};
         ov_line_cnt  <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         dcnt_r       <= dcnt_nxt_s;
         o_fval       <= fval_nxt_s;
         o_lval       <= lval_nxt_s;
         o_frame_done <= done_nxt_s;
         ov_pix_cnt   <= pix_nxt_s;
         ov_line_cnt  <= line_nxt_s;
      end
   end

   // Pending trigger: a new trigger wins over consumption, so one arriving in
   // the consuming cycle stays pending; a second trigger while set is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trig_pend_r <= 1'b0;
      end else if (i_trigger) begin
         trig_pend_r <= 1'b1;
      end else if (consume_s) begin
         trig_pend_r <= 1'b0;
      end else begin
         trig_pend_r <= trig_pend_r;
      end
   end

endmodule
